// File: rtl/bitty_ram_arbiter_pkg.sv
// Shared definitions for the bitty data-RAM arbiter: bus widths, FSM
// encodings, owner constants and the per-master access bundle.
package bitty_ram_arbiter_pkg;

    localparam int unsigned DATA_ADDR_W = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned LOCK_CNT_W  = 8;

    // The state register holds the previous cycle's owner of the RAM.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_LOCK1 = 2'd3
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef struct packed {
        logic                   we;
        logic [DATA_ADDR_W-1:0] addr;
        logic [SEL_W-1:0]       sel;
        logic [DATA_W-1:0]      wdata;
    } arb_acc_t;

endpackage

// File: rtl/bitty_ram_arbiter_rr2.sv
// Two-way round-robin pick between m0 (req_i[0]) and m1 (req_i[1]);
// an active m1 lock overrides the rotation.
module bitty_ram_arbiter_rr2
    import bitty_ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    input  logic       lock_hold_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        gnt_o = 2'b00;
        if (lock_hold_i) begin
            gnt_o = 2'b10;
        end else if (&req_i) begin
            gnt_o = (last_owner_i == ARB_M1) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/bitty_ram_arbiter.sv
// Shares the single-ported data RAM between the core (m0) and a second master
// (m1). Optional bounded m1 lock is enabled by defining BITTY_ARB_LOCK_EN.
module bitty_ram_arbiter
    import bitty_ram_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [DATA_ADDR_W-1:0] m0_addr,
    input  logic [SEL_W-1:0]       m0_sel,
    input  logic [DATA_W-1:0]      m0_wdata,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [DATA_W-1:0]      m0_rdata,

    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [DATA_ADDR_W-1:0] m1_addr,
    input  logic [SEL_W-1:0]       m1_sel,
    input  logic [DATA_W-1:0]      m1_wdata,
    input  logic                   m1_lock,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [DATA_W-1:0]      m1_rdata,

    output logic                   ram_ce,
    output logic                   ram_we,
    output logic [DATA_ADDR_W-1:0] ram_addr,
    output logic [SEL_W-1:0]       ram_sel,
    output logic [DATA_W-1:0]      ram_data_o,
    input  logic [DATA_W-1:0]      ram_data_i
);

    logic [1:0] req;
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       lock_hold;
    logic       m1_locking;
    arb_acc_t   acc;

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;

    assign req = {m1_req, m0_req};

`ifdef BITTY_ARB_LOCK_EN
    localparam logic [LOCK_CNT_W-1:0] LockMax = LOCK_CNT_W'(LOCK_MAX);

    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    assign m1_locking = m1_lock;
    assign lock_hold  = (state_q == ARB_LOCK1) && m1_req && m1_lock &&
                        (lock_cnt_q < LockMax);

    // An expired lock that m1 wins again starts a fresh run at 1.
    always_comb begin
        lock_cnt_d = '0;
        if (gnt[1] && m1_lock) begin
            lock_cnt_d = (lock_cnt_q == LockMax) ? LOCK_CNT_W'(1)
                                                 : lock_cnt_q + LOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock_cfg;

    assign m1_locking      = 1'b0;
    assign lock_hold       = 1'b0;
    assign unused_lock_cfg = ^{m1_lock, state_q, LOCK_CNT_W'(LOCK_MAX)};
`endif

    bitty_ram_arbiter_rr2 u_rr2 (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .lock_hold_i  (lock_hold),
        .gnt_o        (rr_gnt)
    );

    // NOTE: grants are combinational from the requests, so they are masked
    // by reset to keep the RAM and both masters quiet while reset is held.
    assign gnt = rr_gnt & {2{rst}};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= ARB_M1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= ARB_M0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Next-state: owner tracking and read-return bookkeeping
    always_comb begin
        state_d      = ARB_IDLE;
        last_owner_d = last_owner_q;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;
        if (gnt[0]) begin
            state_d      = ARB_GNT0;
            last_owner_d = ARB_M0;
            rd_pend_d    = !m0_we;
            rd_owner_d   = ARB_M0;
        end else if (gnt[1]) begin
            state_d      = m1_locking ? ARB_LOCK1 : ARB_GNT1;
            last_owner_d = ARB_M1;
            rd_pend_d    = !m1_we;
            rd_owner_d   = ARB_M1;
        end
    end

    // Outputs: RAM request mux and read-data steering
    always_comb begin
        acc = '0;
        if (gnt[0]) begin
            acc = '{we: m0_we, addr: m0_addr, sel: m0_sel, wdata: m0_wdata};
        end else if (gnt[1]) begin
            acc = '{we: m1_we, addr: m1_addr, sel: m1_sel, wdata: m1_wdata};
        end
    end

    assign m0_gnt     = gnt[0];
    assign m1_gnt     = gnt[1];

    assign ram_ce     = |gnt;
    assign ram_we     = acc.we;
    assign ram_addr   = acc.addr;
    assign ram_sel    = acc.sel;
    assign ram_data_o = acc.wdata;

    assign m0_rvalid  = rd_pend_q && (rd_owner_q == ARB_M0);
    assign m1_rvalid  = rd_pend_q && (rd_owner_q == ARB_M1);
    assign m0_rdata   = m0_rvalid ? ram_data_i : '0;
    assign m1_rdata   = m1_rvalid ? ram_data_i : '0;

endmodule
